// File: rtl/rr_port_arbiter.sv
// rr_port_arbiter: 16-port round-robin arbiter, one-hot + index grant behind valid/ready.
// Define ARB_STATS_EN to add the saturating accepted-grant counter (grant_cnt).
module rr_port_arbiter #(
    parameter int PORT_NUM = 16,
    parameter int IDX_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PORT_NUM-1:0] req,
    output logic                gnt_valid,
    input  logic                gnt_ready,
    output logic [PORT_NUM-1:0] gnt_onehot,
    output logic [IDX_W-1:0]    gnt_idx,
    output logic [3:0]          ptr
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]         grant_cnt
`endif
);

    localparam int PTR_W = 4;
    localparam logic [IDX_W-1:0] IDX_NONE = IDX_W'(PORT_NUM);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e              state_q;
    logic                gnt_valid_q;
    logic [PORT_NUM-1:0] gnt_onehot_q;
    logic [IDX_W-1:0]    gnt_idx_q;
    logic [PTR_W-1:0]    ptr_q;

    logic [PTR_W-1:0]    search_ptr;
    logic [PORT_NUM-1:0] search_vec;
    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic [PORT_NUM-1:0] win_onehot;

    // In GRANT the search already assumes the handshake: start past the
    // current winner and exclude its own request.
    always_comb begin
        logic [PTR_W-1:0] pos;
        pos        = '0;
        search_ptr = ptr_q;
        search_vec = req;
        if (state_q == GRANT) begin
            search_ptr = gnt_idx_q[PTR_W-1:0] + PTR_W'(1);
            search_vec = req & ~gnt_onehot_q;
        end
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            pos = search_ptr + PTR_W'(i);
            if (!win_found && search_vec[pos]) begin
                win_found = 1'b1;
                win_idx   = pos;
            end
        end
        win_onehot = PORT_NUM'(1) << win_idx;
    end

`ifdef ARB_STATS_EN
    logic [31:0] cnt_q;
    assign grant_cnt = cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_valid_q  <= 1'b0;
            gnt_onehot_q <= '0;
            gnt_idx_q    <= IDX_NONE;
            ptr_q        <= '0;
`ifdef ARB_STATS_EN
            cnt_q        <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q      <= GRANT;
                        gnt_valid_q  <= 1'b1;
                        gnt_onehot_q <= win_onehot;
                        gnt_idx_q    <= IDX_W'(win_idx);
                    end
                end
                GRANT: begin
                    if (gnt_ready) begin
                        ptr_q <= gnt_idx_q[PTR_W-1:0] + PTR_W'(1);
`ifdef ARB_STATS_EN
                        if (cnt_q != '1) cnt_q <= cnt_q + 32'd1;
`endif
                        if (win_found) begin
                            gnt_onehot_q <= win_onehot;
                            gnt_idx_q    <= IDX_W'(win_idx);
                        end else begin
                            state_q      <= IDLE;
                            gnt_valid_q  <= 1'b0;
                            gnt_onehot_q <= '0;
                            gnt_idx_q    <= IDX_NONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_onehot = gnt_onehot_q;
    assign gnt_idx    = gnt_idx_q;
    assign ptr        = ptr_q;

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed testbench for rr_port_arbiter; drives and samples on the falling edge.
// Builds with or without ARB_STATS_EN.
module tb_rr_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        gnt_valid;
    logic        gnt_ready;
    logic [15:0] gnt_onehot;
    logic [4:0]  gnt_idx;
    logic [3:0]  ptr;
`ifdef ARB_STATS_EN
    logic [31:0] grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt_valid  (gnt_valid),
        .gnt_ready  (gnt_ready),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .ptr        (ptr)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_chk(input string tag, input logic [3:0] p);
        check({tag, ".valid"}, 32'(gnt_valid), 32'd0);
        check({tag, ".idx"}, 32'(gnt_idx), 32'd16);
        check({tag, ".onehot"}, 32'(gnt_onehot), 32'd0);
        check({tag, ".ptr"}, 32'(ptr), 32'(p));
    endtask

    task automatic gnt_chk(input string tag, input int idx);
        check({tag, ".valid"}, 32'(gnt_valid), 32'd1);
        check({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
        check({tag, ".onehot"}, 32'(gnt_onehot), 32'd1 << idx);
    endtask

    initial begin
        rst       = 1'b1;
        req       = 16'hFFFF;
        gnt_ready = 1'b0;

        // 1: reset held two cycles with all requests up
        repeat (2) begin
            @(negedge clk);
            idle_chk("rst", 4'd0);
        end
`ifdef ARB_STATS_EN
        check("rst.cnt", grant_cnt, 32'd0);
`endif

        // 2: single request, grant then handshake
        rst       = 1'b0;
        req       = 16'h0001;
        gnt_ready = 1'b1;
        @(negedge clk);
        gnt_chk("single", 0);
        @(negedge clk);
        idle_chk("single_done", 4'd1);
        req = 16'h0000;
        @(negedge clk);
        idle_chk("ready_idle", 4'd1);

        // 3: full request, back-to-back rotation from ptr=0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 16'hFFFF;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            gnt_chk($sformatf("rot%0d", k), k % 16);
        end
        req = 16'h0000;
        @(negedge clk);
        idle_chk("rot_done", 4'd1);
`ifdef ARB_STATS_EN
        check("rot.cnt", grant_cnt, 32'd17);
`endif

        // 4: wrap past 14,15 to port 0
        req = 16'h2000;
        @(negedge clk);
        gnt_chk("set13", 13);
        @(negedge clk);
        idle_chk("ptr14", 4'd14);
        req = 16'h2001;
        @(negedge clk);
        gnt_chk("wrap0", 0);
        @(negedge clk);
        gnt_chk("wrap13", 13);
        check("wrap.ptr", 32'(ptr), 32'd1);
        req = 16'h0000;
        @(negedge clk);
        idle_chk("wrap_done", 4'd14);

        // 5: grant held under backpressure while req changes
        req       = 16'h0030;
        gnt_ready = 1'b0;
        @(negedge clk);
        gnt_chk("hold0", 4);
        req = 16'h0020;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            gnt_chk($sformatf("hold%0d", k), 4);
            check("hold.ptr", 32'(ptr), 32'd14);
        end
        gnt_ready = 1'b1;
        @(negedge clk);
        gnt_chk("after_hold", 5);
        check("after_hold.ptr", 32'(ptr), 32'd5);
        @(negedge clk);
        idle_chk("hold_done", 4'd6);
`ifdef ARB_STATS_EN
        check("hold.cnt", grant_cnt, 32'd22);
`endif

        // 6: reset with a grant in flight and ready high
        req       = 16'h0080;
        gnt_ready = 1'b0;
        @(negedge clk);
        gnt_chk("inflight", 7);
        rst       = 1'b1;
        gnt_ready = 1'b1;
        @(negedge clk);
        idle_chk("rst_flight", 4'd0);
`ifdef ARB_STATS_EN
        check("rst_flight.cnt", grant_cnt, 32'd0);
`endif
        rst = 1'b0;
        req = 16'h0000;
        @(negedge clk);
        idle_chk("final", 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
